// File: rtl/instr_encoder.sv
// instr_encoder: builds a 32-bit MIPS32 instruction word from a byte-serial
// ASCII mnemonic and a set of parallel operand fields.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   ch_valid/ch_data  mnemonic character stream; 8'h00 or 8'h20 terminates
//   ch_ready          character accepted when ch_valid && ch_ready
//   opnd_*            rs, rt, rd, sa, imm, tgt; sampled with the terminator
//   instr_valid       encoded word available
//   instr/instr_err   word and error flag (unknown/empty/overflowed mnemonic)
//   instr_ready       sink accepts when instr_valid && instr_ready
//
// Optional feature: define INSTR_ENCODER_COP0_EN to add MFC0, MTC0 and ERET.
// Without it those mnemonics decode as unknown.
module instr_encoder #(
  parameter int MAX_CHARS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic [4:0]  opnd_rs,
  input  logic [4:0]  opnd_rt,
  input  logic [4:0]  opnd_rd,
  input  logic [4:0]  opnd_sa,
  input  logic [15:0] opnd_imm,
  input  logic [25:0] opnd_tgt,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        instr_err,
  input  logic        instr_ready
);

  localparam int BW = 8 * MAX_CHARS;
  localparam int CW = $clog2(MAX_CHARS + 1);

  typedef enum logic [1:0] {COLLECT = 2'd0, LOOKUP = 2'd1, OUT = 2'd2} state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   mbuf;
  logic [CW-1:0]   cnt;
  logic            ovf;
  logic            rdy_q;
  logic [4:0]      rs_q, rt_q, rd_q, sa_q;
  logic [15:0]     imm_q;
  logic [25:0]     tgt_q;

  logic            ch_acc, is_term, ch_legal;
  logic [7:0]      ch_up;
  logic [25:0]     rfld, ifld;
  logic [31:0]     enc_word;
  logic            enc_err;

  assign ch_ready    = rdy_q;
  assign instr_valid = (state == OUT);
  assign ch_acc      = ch_valid && ch_ready;
  assign is_term     = (ch_data == 8'h00) || (ch_data == 8'h20);
  assign ch_up       = (ch_data >= 8'h61 && ch_data <= 8'h7A) ? ch_data - 8'h20 : ch_data;
  assign ch_legal    = (ch_up >= 8'h41 && ch_up <= 8'h5A) || (ch_up >= 8'h30 && ch_up <= 8'h39);
  assign rfld        = {rs_q, rt_q, rd_q, sa_q};
  assign ifld        = {rs_q, rt_q, imm_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: if (ch_acc && is_term) state_nx = LOOKUP;
      LOOKUP:  state_nx = OUT;
      OUT:     if (instr_ready) state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
  end

  // The buffer is right-aligned, so it compares directly against a
  // zero-extended string literal.
  always_comb begin
    enc_word = 32'h0;
    enc_err  = 1'b0;
    case (mbuf)
      BW'("AND"):     enc_word = {6'h00, rfld, 6'h24};
      BW'("OR"):      enc_word = {6'h00, rfld, 6'h25};
      BW'("XOR"):     enc_word = {6'h00, rfld, 6'h26};
      BW'("NOR"):     enc_word = {6'h00, rfld, 6'h27};
      BW'("SLL"):     enc_word = {6'h00, rfld, 6'h00};
      BW'("SRL"):     enc_word = {6'h00, rfld, 6'h02};
      BW'("SRA"):     enc_word = {6'h00, rfld, 6'h03};
      BW'("SLLV"):    enc_word = {6'h00, rfld, 6'h04};
      BW'("SRLV"):    enc_word = {6'h00, rfld, 6'h06};
      BW'("SRAV"):    enc_word = {6'h00, rfld, 6'h07};
      BW'("MFHI"):    enc_word = {6'h00, rfld, 6'h10};
      BW'("MTHI"):    enc_word = {6'h00, rfld, 6'h11};
      BW'("MFLO"):    enc_word = {6'h00, rfld, 6'h12};
      BW'("MTLO"):    enc_word = {6'h00, rfld, 6'h13};
      BW'("ADD"):     enc_word = {6'h00, rfld, 6'h20};
      BW'("ADDU"):    enc_word = {6'h00, rfld, 6'h21};
      BW'("SUB"):     enc_word = {6'h00, rfld, 6'h22};
      BW'("SUBU"):    enc_word = {6'h00, rfld, 6'h23};
      BW'("SLT"):     enc_word = {6'h00, rfld, 6'h2A};
      BW'("SLTU"):    enc_word = {6'h00, rfld, 6'h2B};
      BW'("MULT"):    enc_word = {6'h00, rfld, 6'h18};
      BW'("MULTU"):   enc_word = {6'h00, rfld, 6'h19};
      BW'("DIV"):     enc_word = {6'h00, rfld, 6'h1A};
      BW'("DIVU"):    enc_word = {6'h00, rfld, 6'h1B};
      BW'("JR"):      enc_word = {6'h00, rfld, 6'h08};
      BW'("JALR"):    enc_word = {6'h00, rfld, 6'h09};
      // The 20-bit code field of the trap instructions is always zero.
      BW'("SYSCALL"): enc_word = {26'h0, 6'h0C};
      BW'("BREAK"):   enc_word = {26'h0, 6'h0D};
      BW'("ANDI"):    enc_word = {6'h0C, ifld};
      BW'("XORI"):    enc_word = {6'h0E, ifld};
      BW'("LUI"):     enc_word = {6'h0F, ifld};
      BW'("ORI"):     enc_word = {6'h0D, ifld};
      BW'("ADDI"):    enc_word = {6'h08, ifld};
      BW'("ADDIU"):   enc_word = {6'h09, ifld};
      BW'("SLTI"):    enc_word = {6'h0A, ifld};
      BW'("SLTIU"):   enc_word = {6'h0B, ifld};
      BW'("BEQ"):     enc_word = {6'h04, ifld};
      BW'("BNE"):     enc_word = {6'h05, ifld};
      BW'("BGTZ"):    enc_word = {6'h07, ifld};
      BW'("BLEZ"):    enc_word = {6'h06, ifld};
      BW'("LB"):      enc_word = {6'h20, ifld};
      BW'("LBU"):     enc_word = {6'h24, ifld};
      BW'("LH"):      enc_word = {6'h21, ifld};
      BW'("LHU"):     enc_word = {6'h25, ifld};
      BW'("LW"):      enc_word = {6'h23, ifld};
      BW'("SB"):      enc_word = {6'h28, ifld};
      BW'("SH"):      enc_word = {6'h29, ifld};
      BW'("SW"):      enc_word = {6'h2B, ifld};
      // REGIMM: the rt slot carries the branch condition code.
      BW'("BGEZ"):    enc_word = {6'h01, rs_q, 5'h01, imm_q};
      BW'("BGEZAL"):  enc_word = {6'h01, rs_q, 5'h11, imm_q};
      BW'("BLTZ"):    enc_word = {6'h01, rs_q, 5'h00, imm_q};
      BW'("BLTZAL"):  enc_word = {6'h01, rs_q, 5'h10, imm_q};
      BW'("J"):       enc_word = {6'h02, tgt_q};
      BW'("JAL"):     enc_word = {6'h03, tgt_q};
      BW'("NOP"):     enc_word = 32'h0;
`ifdef INSTR_ENCODER_COP0_EN
      BW'("MFC0"):    enc_word = {6'h10, 5'h00, rt_q, rd_q, 8'h00, 3'b000};
      BW'("MTC0"):    enc_word = {6'h10, 5'h04, rt_q, rd_q, 11'h0};
      BW'("ERET"):    enc_word = 32'h42000018;
`endif
      default:        enc_err  = 1'b1;
    endcase
    if (ovf || cnt == '0) begin
      enc_word = 32'h0;
      enc_err  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mbuf      <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      rdy_q     <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      sa_q      <= '0;
      imm_q     <= '0;
      tgt_q     <= '0;
      instr     <= '0;
      instr_err <= 1'b0;
    end else begin
      // Registered ready: high in every cycle spent in COLLECT except the
      // first one after reset release.
      rdy_q <= (state_nx == COLLECT);
      case (state)
        COLLECT: begin
          if (ch_acc) begin
            if (is_term) begin
              rs_q  <= opnd_rs;
              rt_q  <= opnd_rt;
              rd_q  <= opnd_rd;
              sa_q  <= opnd_sa;
              imm_q <= opnd_imm;
              tgt_q <= opnd_tgt;
            end else if (!ch_legal || cnt == CW'(MAX_CHARS)) begin
              ovf <= 1'b1;
            end else begin
              mbuf <= {mbuf[BW-9:0], ch_up};
              cnt  <= cnt + CW'(1);
            end
          end
        end
        LOOKUP: begin
          instr     <= enc_word;
          instr_err <= enc_err;
        end
        OUT: begin
          if (instr_ready) begin
            mbuf <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, output hold,
// reset in mid-flight, and randomized mnemonics checked against a
// string-keyed opcode table model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic [4:0]  opnd_rs, opnd_rt, opnd_rd, opnd_sa;
  logic [15:0] opnd_imm;
  logic [25:0] opnd_tgt;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_err;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  logic [5:0] rfn[string];
  logic [5:0] iop[string];
  logic [4:0] rim[string];
  logic [5:0] jop[string];
  string      names[$];

  instr_encoder #(.MAX_CHARS(7)) dut (
    .clk(clk), .rst(rst),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .opnd_rs(opnd_rs), .opnd_rt(opnd_rt), .opnd_rd(opnd_rd), .opnd_sa(opnd_sa),
    .opnd_imm(opnd_imm), .opnd_tgt(opnd_tgt),
    .instr_valid(instr_valid), .instr(instr), .instr_err(instr_err),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic void init_tables();
    rfn["AND"]=6'h24; rfn["OR"]=6'h25; rfn["XOR"]=6'h26; rfn["NOR"]=6'h27;
    rfn["SLL"]=6'h00; rfn["SRL"]=6'h02; rfn["SRA"]=6'h03; rfn["SLLV"]=6'h04;
    rfn["SRLV"]=6'h06; rfn["SRAV"]=6'h07; rfn["MFHI"]=6'h10; rfn["MTHI"]=6'h11;
    rfn["MFLO"]=6'h12; rfn["MTLO"]=6'h13; rfn["ADD"]=6'h20; rfn["ADDU"]=6'h21;
    rfn["SUB"]=6'h22; rfn["SUBU"]=6'h23; rfn["SLT"]=6'h2A; rfn["SLTU"]=6'h2B;
    rfn["MULT"]=6'h18; rfn["MULTU"]=6'h19; rfn["DIV"]=6'h1A; rfn["DIVU"]=6'h1B;
    rfn["JR"]=6'h08; rfn["JALR"]=6'h09; rfn["SYSCALL"]=6'h0C; rfn["BREAK"]=6'h0D;
    iop["ANDI"]=6'h0C; iop["XORI"]=6'h0E; iop["LUI"]=6'h0F; iop["ORI"]=6'h0D;
    iop["ADDI"]=6'h08; iop["ADDIU"]=6'h09; iop["SLTI"]=6'h0A; iop["SLTIU"]=6'h0B;
    iop["BEQ"]=6'h04; iop["BNE"]=6'h05; iop["BGTZ"]=6'h07; iop["BLEZ"]=6'h06;
    iop["LB"]=6'h20; iop["LBU"]=6'h24; iop["LH"]=6'h21; iop["LHU"]=6'h25;
    iop["LW"]=6'h23; iop["SB"]=6'h28; iop["SH"]=6'h29; iop["SW"]=6'h2B;
    rim["BGEZ"]=5'h01; rim["BGEZAL"]=5'h11; rim["BLTZ"]=5'h00; rim["BLTZAL"]=5'h10;
    jop["J"]=6'h02; jop["JAL"]=6'h03;
    foreach (rfn[k]) names.push_back(k);
    foreach (iop[k]) names.push_back(k);
    foreach (rim[k]) names.push_back(k);
    foreach (jop[k]) names.push_back(k);
    names.push_back("NOP");
    names.push_back("MFC0"); names.push_back("MTC0"); names.push_back("ERET");
  endfunction

  // Reference: returns {err, word} for a mnemonic typed as string s.
  function automatic logic [32:0] model(input string s, input logic [4:0] rs, rt, rd, sa,
                                        input logic [15:0] imm, input logic [25:0] tgt);
    string u;
    if (s.len() == 0 || s.len() > 7) return {1'b1, 32'h0};
    u = s.toupper();
    for (int i = 0; i < u.len(); i++)
      if (!((u[i] >= "A" && u[i] <= "Z") || (u[i] >= "0" && u[i] <= "9"))) return {1'b1, 32'h0};
    if (u == "SYSCALL" || u == "BREAK") return {1'b0, 26'h0, rfn[u]};
    if (rfn.exists(u)) return {1'b0, 6'h00, rs, rt, rd, sa, rfn[u]};
    if (iop.exists(u)) return {1'b0, iop[u], rs, rt, imm};
    if (rim.exists(u)) return {1'b0, 6'h01, rs, rim[u], imm};
    if (jop.exists(u)) return {1'b0, jop[u], tgt};
    if (u == "NOP") return {1'b0, 32'h0};
`ifdef INSTR_ENCODER_COP0_EN
    if (u == "MFC0") return {1'b0, 6'h10, 5'h00, rt, rd, 11'h0};
    if (u == "MTC0") return {1'b0, 6'h10, 5'h04, rt, rd, 11'h0};
    if (u == "ERET") return {1'b0, 32'h42000018};
`endif
    return {1'b1, 32'h0};
  endfunction

  // Called and returns at a falling edge; the char is taken on the rising
  // edge in between once ch_ready is seen high.
  task automatic send_char(input byte c);
    int n = 0;
    ch_valid = 1'b1;
    ch_data  = c;
    while (!ch_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL ch_ready_timeout got=%b want=1", ch_ready);
    end
    @(negedge clk);
    ch_valid = 1'b0;
  endtask

  task automatic rand_opnds();
    opnd_rs  = 5'($urandom); opnd_rt = 5'($urandom); opnd_rd = 5'($urandom);
    opnd_sa  = 5'($urandom); opnd_imm = 16'($urandom); opnd_tgt = 26'($urandom);
  endtask

  task automatic send_mnem(input string s, input byte term);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    send_char(term);
    rand_opnds();  // operands must already be latched
  endtask

  // Entered at the falling edge right after the terminator edge (LOOKUP).
  task automatic expect_word(input string tag, input logic [32:0] exp, input int hold);
    int n = 0;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid got=%b want=0", tag, instr_valid); end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL %s latency valid got=%b want=1", tag, instr_valid); end
    while (instr_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if ({instr_err, instr} !== exp)
      begin errors++; $display("FAIL %s word got=%b/%h want=%b/%h", tag, instr_err, instr, exp[32], exp[31:0]); end
    for (int i = 0; i < hold; i++) begin
      ch_valid = 1'b1; ch_data = 8'h5A;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || ch_ready !== 1'b0 || {instr_err, instr} !== exp)
        begin errors++; $display("FAIL %s hold v=%b rdy=%b word=%b/%h want v=1 rdy=0 %b/%h", tag,
                                 instr_valid, ch_ready, instr_err, instr, exp[32], exp[31:0]); end
    end
    ch_valid = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checks++;
    if (ch_ready !== 1'b1 || instr_valid !== 1'b0)
      begin errors++; $display("FAIL %s release rdy=%b v=%b want rdy=1 v=0", tag, ch_ready, instr_valid); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ch_ready, instr_valid, instr_err, instr} !== 35'h0)
      begin errors++; $display("FAIL reset_state got rdy=%b v=%b e=%b i=%h want all 0", ch_ready, instr_valid, instr_err, instr); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ch_ready); end
  endtask

  task automatic test_directed();
    opnd_rs = 5'd1; opnd_rt = 5'd2; opnd_rd = 5'd3; opnd_sa = 5'd0;
    send_mnem("ADDU", 8'h00);   expect_word("addu", {1'b0, 32'h00221821}, 0);
    opnd_rs = 5'd29; opnd_rt = 5'd8; opnd_imm = 16'h0010;
    send_mnem("lw", 8'h20);     expect_word("lw", {1'b0, 32'h8FA80010}, 0);
    opnd_rs = 5'd4; opnd_rt = 5'd31; opnd_imm = 16'hFFFE;
    send_mnem("BGEZAL", 8'h00); expect_word("bgezal", {1'b0, 32'h0491FFFE}, 0);
    opnd_tgt = 26'h0100000;
    send_mnem("J", 8'h00);      expect_word("j", {1'b0, 32'h08100000}, 0);
    send_mnem("ERET", 8'h00);
`ifdef INSTR_ENCODER_COP0_EN
    expect_word("eret", {1'b0, 32'h42000018}, 0);
`else
    expect_word("eret", {1'b1, 32'h0}, 0);
`endif
    send_mnem("FOO", 8'h00);      expect_word("foo", {1'b1, 32'h0}, 0);
    send_mnem("ADDIUXYZ", 8'h00); expect_word("overflow", {1'b1, 32'h0}, 0);
    send_mnem("", 8'h20);         expect_word("empty", {1'b1, 32'h0}, 0);
    opnd_rs = 5'd7; opnd_rt = 5'd9;
    send_mnem("SYSCALL", 8'h00);  expect_word("syscall", {1'b0, 32'h0000000C}, 0);
  endtask

  task automatic test_hold();
    opnd_rs = 5'd5; opnd_rt = 5'd6; opnd_rd = 5'd7; opnd_sa = 5'd1;
    send_mnem("SUB", 8'h00);
    expect_word("hold", {1'b0, 6'h00, 5'd5, 5'd6, 5'd7, 5'd1, 6'h22}, 3);
    // Held-off 'Z' chars must not have leaked into the next mnemonic.
    opnd_rs = 5'd10; opnd_rt = 5'd11; opnd_rd = 5'd12; opnd_sa = 5'd0;
    send_mnem("OR", 8'h00);
    expect_word("after_hold", {1'b0, 6'h00, 5'd10, 5'd11, 5'd12, 5'd0, 6'h25}, 0);
  endtask

  task automatic test_reset_mid();
    opnd_rs = 5'd1; opnd_rt = 5'd2; opnd_rd = 5'd3;
    send_mnem("ADDU", 8'h00);  // now in LOOKUP
    rst = 1'b1;
    #1;
    checks++;
    if ({ch_ready, instr_valid, instr_err, instr} !== 35'h0)
      begin errors++; $display("FAIL rst_lookup got rdy=%b v=%b e=%b i=%h want all 0", ch_ready, instr_valid, instr_err, instr); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || ch_ready !== 1'b1)
      begin errors++; $display("FAIL rst_lookup_after v=%b rdy=%b want v=0 rdy=1", instr_valid, ch_ready); end
    send_char("S"); send_char("L"); send_char("T");
    rst = 1'b1;
    #1;
    checks++;
    if ({ch_ready, instr_valid, instr_err, instr} !== 35'h0)
      begin errors++; $display("FAIL rst_collect got rdy=%b v=%b e=%b i=%h want all 0", ch_ready, instr_valid, instr_err, instr); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    send_mnem("NOP", 8'h00);
    expect_word("nop_after_rst", {1'b0, 32'h0}, 0);
  endtask

  task automatic test_random();
    string s;
    logic [32:0] exp;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(3, 0) != 0) begin
        s = names[$urandom_range(names.size() - 1, 0)];
        for (int i = 0; i < s.len(); i++)
          if (s[i] >= "A" && s[i] <= "Z" && $urandom_range(1, 0) == 1) s[i] = s[i] + 8'h20;
      end else begin
        s = "";
        for (int i = 0; i < int'($urandom_range(9, 1)); i++) begin
          byte c;
          c = ($urandom_range(7, 0) == 0) ? byte'($urandom_range(8'h7E, 8'h21))
                                           : byte'($urandom_range(8'h5A, 8'h41));
          s = {s, string'(c)};
        end
      end
      rand_opnds();
      exp = model(s, opnd_rs, opnd_rt, opnd_rd, opnd_sa, opnd_imm, opnd_tgt);
      send_mnem(s, ($urandom_range(1, 0) == 1) ? 8'h20 : 8'h00);
      expect_word({"rnd_", s}, exp, int'($urandom_range(2, 0)));
    end
  endtask

  initial begin
    ch_valid = 1'b0; ch_data = 8'h00; instr_ready = 1'b0;
    opnd_rs = '0; opnd_rt = '0; opnd_rd = '0; opnd_sa = '0; opnd_imm = '0; opnd_tgt = '0;
    init_tables();
    @(negedge clk);
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
